barrel_shifter: RTL and testbench
=================================

Name: barrel_shifter

Overview:
- Registered logarithmic barrel shifter for the datapath's shift instructions: SLL, SRL, SRA, and a pass-through mode.
- Operands are sampled on the clock edge when a valid strobe is asserted.
- The result appears one cycle later with a matching valid flag. Sits in the execute stage beside the ALU.

Parameters:
- WIDTH, 64, data width in bits; must be a power of two, minimum 8.
- SHAMT_W, $clog2(WIDTH) = 6, shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies din/shamt/mode this cycle.
- din  input  WIDTH  operand to shift.
- shamt  input  SHAMT_W  shift distance, 0..WIDTH-1.
- mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=pass-through.
- out_valid  output  1  dout holds a fresh result.
- dout  output  WIDTH  shifted result.

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, out_valid=0. Both are held while reset is low.
- Latency is 1 cycle. On a clk rise with in_valid=1: dout <= f(din, shamt, mode), and out_valid <= 1.
- On a clk rise with in_valid=0: out_valid <= 0 and dout holds its previous value.
- There is no backpressure. A new operation can be accepted every cycle.
- SLL: din << shamt, zero-filled from the LSB.
- SRL: din >> shamt, zero-filled from the MSB.
- SRA: din >> shamt, filled with din[WIDTH-1].
- mode 11: dout = din unchanged, regardless of shamt.
- shamt=0: dout = din in every mode.
- shamt=WIDTH-1: SLL leaves din[0] at the MSB. SRL leaves din[WIDTH-1] at the LSB. SRA yields all copies of the sign bit.
- Shift amounts of WIDTH or more cannot be encoded and are out of scope.
- Datapath structure: SHAMT_W cascaded stages. Stage k conditionally shifts by 2^k when shamt[k]=1.
- Left and right shifts share the right-shift network by bit-reversing the input and output for SLL.
- The combinational path from input to register is free of latches and has no X propagation for defined inputs.
- If reset is released mid-stream, the first in_valid after release is processed normally. No residual state is kept.

Optional Feature:
- Macro: BARREL_SHIFTER_PIPE_EN.
- Defined: a second register stage splits the network after stage SHAMT_W/2, so latency is 2 cycles. out_valid and the mode/sign bits are pipelined alongside the data, throughput stays one operation per cycle, and both stages reset to 0.
- Undefined: single register as above, latency 1.

Decomposition:
- shifter_pkg holds the shift_mode_e enum (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_PASS=2'b11) and the default WIDTH constant.
- One sub-module, shift_stage: a combinational right-shift by a constant 2^k with a fill-bit input.
- It is instantiated SHAMT_W times in a generate loop.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> dout=0 and out_valid=0 immediately, without waiting for a clock edge.
- SLL: din=64'h1, shamt=3, mode=00, in_valid=1 -> next cycle dout=64'h8, out_valid=1.
- SRL vs SRA: din=64'h8000_0000_0000_0000, shamt=1.
  - mode=01 -> dout=64'h4000_0000_0000_0000.
  - mode=10 -> dout=64'hC000_0000_0000_0000.
- Pass-through: din=64'h1234_5678_9ABC_DEF0, mode=11, shamt=7 -> dout=64'h1234_5678_9ABC_DEF0.
- Boundaries with din=64'h8000_0000_0000_0001:
  - SRA shamt=63 -> dout=all ones.
  - SRL shamt=63 -> dout=64'h1.
  - SLL shamt=63 -> dout=64'h8000_0000_0000_0000.
  - shamt=0 in every mode -> dout=din.
- Back-to-back random ops at full rate with in_valid toggling -> every result matches a reference model at the correct latency, and out_valid=0 after each idle cycle.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the barrel shifter.
// Mode decoding lives here so the datapath stays mode-agnostic.
package shifter_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_PASS = 2'b11
  } shift_mode_e;

  // Left shifts run through the right-shift network on bit-reversed data.
  function automatic logic mode_reverses(
    input shift_mode_e m
  );
    return m == SHIFT_SLL;
  endfunction

  // Only arithmetic right shifts replicate the sign bit.
  function automatic logic mode_signed(
    input shift_mode_e m
  );
    return m == SHIFT_SRA;
  endfunction

  // Pass-through forces a zero distance so the network is transparent.
  function automatic logic mode_shifts(
    input shift_mode_e m
  );
    return m != SHIFT_PASS;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the logarithmic shifter.
// Right-shifts by the constant SHIFT when enabled, filling with fill.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] fillv;
  logic [WIDTH-1:0] moved;

  // Fill pattern occupies the SHIFT vacated MSB positions.
  always_comb begin
    fillv = {WIDTH{fill}} << (WIDTH - SHIFT);
    moved = (din >> SHIFT) | fillv;
    dout  = en ? moved : din;
  end

endmodule

// File: rtl/barrel_shifter.sv
// Registered log barrel shifter: SLL, SRL, SRA, pass-through.
// Define BARREL_SHIFTER_PIPE_EN to split the network (latency 2).
module barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  output logic [WIDTH-1:0]   dout
);

  localparam int HALF = SHAMT_W / 2;

  shift_mode_e        m_lo;
  logic               rev_lo;
  logic               fill_lo;
  logic [SHAMT_W-1:0] sh_lo;
  logic [WIDTH-1:0]   pre;

  logic [SHAMT_W-1:HALF] sh_hi;
  logic                  fill_hi;
  logic                  rev_hi;
  logic                  v_hi;
  logic [WIDTH-1:0]      mid;

  logic [WIDTH-1:0] st_in  [SHAMT_W];
  logic [WIDTH-1:0] st_out [SHAMT_W];
  logic [WIDTH-1:0] post;
  logic [WIDTH-1:0] res;

  logic               valid_q;
  logic [WIDTH-1:0]   dout_q;

  assign m_lo = shift_mode_e'(mode);

  // Decode mode and pre-reverse the operand for left shifts.
  always_comb begin
    rev_lo  = mode_reverses(m_lo);
    fill_lo = mode_signed(m_lo) & din[WIDTH-1];
    sh_lo   = mode_shifts(m_lo) ? shamt : '0;
    pre     = din;
    for (int i = 0; i < WIDTH; i++) begin
      pre[i] = rev_lo ? din[WIDTH-1-i] : din[i];
    end
  end

`ifdef BARREL_SHIFTER_PIPE_EN
  logic                  v_q;
  logic [WIDTH-1:0]      mid_q;
  logic [SHAMT_W-1:HALF] sh_q;
  logic                  fill_q;
  logic                  rev_q;

  // Mid-network register: partial result plus the controls still needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      mid_q  <= '0;
      sh_q   <= '0;
      fill_q <= 1'b0;
      rev_q  <= 1'b0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        mid_q  <= st_out[HALF-1];
        sh_q   <= sh_lo[SHAMT_W-1:HALF];
        fill_q <= fill_lo;
        rev_q  <= rev_lo;
      end
    end
  end

  assign mid     = mid_q;
  assign sh_hi   = sh_q;
  assign fill_hi = fill_q;
  assign rev_hi  = rev_q;
  assign v_hi    = v_q;
`else
  assign mid     = st_out[HALF-1];
  assign sh_hi   = sh_lo[SHAMT_W-1:HALF];
  assign fill_hi = fill_lo;
  assign rev_hi  = rev_lo;
  assign v_hi    = in_valid;
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_in[k] = pre;
    end else if (k == HALF) begin : g_mid
      assign st_in[k] = mid;
    end else begin : g_chain
      assign st_in[k] = st_out[k-1];
    end

    if (k < HALF) begin : g_lo
      shift_stage #(
        .WIDTH (WIDTH),
        .SHIFT (1 << k)
      ) u_stage (
        .din  (st_in[k]),
        .en   (sh_lo[k]),
        .fill (fill_lo),
        .dout (st_out[k])
      );
    end else begin : g_hi
      shift_stage #(
        .WIDTH (WIDTH),
        .SHIFT (1 << k)
      ) u_stage (
        .din  (st_in[k]),
        .en   (sh_hi[k]),
        .fill (fill_hi),
        .dout (st_out[k])
      );
    end
  end

  assign post = st_out[SHAMT_W-1];

  // Undo the input reversal for left shifts.
  always_comb begin
    res = post;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = rev_hi ? post[WIDTH-1-i] : post[i];
    end
  end

  // Output register; dout holds across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= v_hi;
      if (v_hi) begin
        dout_q <= res;
      end
    end
  end

  assign out_valid = valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter.
// Reference model plus directed literal vectors.
module tb_barrel_shifter;

`ifdef BARREL_SHIFTER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] din;
  logic [5:0]  shamt;
  logic [1:0]  mode;
  logic        out_valid;
  logic [63:0] dout;

  int tests;
  int fails;

  barrel_shifter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din       (din),
    .shamt     (shamt),
    .mode      (mode),
    .out_valid (out_valid),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_shift(
    input logic [63:0] d,
    input logic [5:0]  s,
    input logic [1:0]  m
  );
    logic [63:0] r;
    case (m)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $signed(d) >>> s;
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic check(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference delay line: result emerges LAT edges after acceptance.
  logic        mv [LAT];
  logic [63:0] md [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        mv[i] <= 1'b0;
        md[i] <= '0;
      end
    end else begin
      mv[0] <= in_valid;
      if (LAT == 1) begin
        if (in_valid) md[0] <= ref_shift(din, shamt, mode);
      end else begin
        md[0] <= ref_shift(din, shamt, mode);
      end
      for (int i = 1; i < LAT; i++) begin
        mv[i] <= mv[i-1];
        if (i < LAT - 1 || mv[i-1]) md[i] <= md[i-1];
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_valid", {63'd0, out_valid}, {63'd0, mv[LAT-1]});
      check("model_dout", dout, md[LAT-1]);
    end
  end

  task automatic directed(
    input string       nm,
    input logic [63:0] d,
    input logic [5:0]  s,
    input logic [1:0]  m,
    input logic [63:0] exp
  );
    @(negedge clk);
    in_valid = 1'b1;
    din      = d;
    shamt    = s;
    mode     = m;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check(nm, dout, exp);
    check({nm, "_v"}, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din      = '0;
    shamt    = '0;
    mode     = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;

    check("pin_sra", ref_shift(64'h8000_0000_0000_0001, 6'd63, 2'b10),
          64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_sll", ref_shift(64'h1, 6'd3, 2'b00), 64'h8);
    check("pin_pass", ref_shift(64'h1234_5678_9ABC_DEF0, 6'd7, 2'b11),
          64'h1234_5678_9ABC_DEF0);

    directed("sll3", 64'h1, 6'd3, 2'b00, 64'h8);
    directed("srl1", 64'h8000_0000_0000_0000, 6'd1, 2'b01,
             64'h4000_0000_0000_0000);
    directed("sra1", 64'h8000_0000_0000_0000, 6'd1, 2'b10,
             64'hC000_0000_0000_0000);
    directed("pass", 64'h1234_5678_9ABC_DEF0, 6'd7, 2'b11,
             64'h1234_5678_9ABC_DEF0);
    directed("sra63", 64'h8000_0000_0000_0001, 6'd63, 2'b10,
             64'hFFFF_FFFF_FFFF_FFFF);
    directed("srl63", 64'h8000_0000_0000_0001, 6'd63, 2'b01, 64'h1);
    directed("sll63", 64'h8000_0000_0000_0001, 6'd63, 2'b00,
             64'h8000_0000_0000_0000);
    directed("sll32", 64'h0000_0000_DEAD_BEEF, 6'd32, 2'b00,
             64'hDEAD_BEEF_0000_0000);
    directed("sra4", 64'hF000_0000_0000_00F0, 6'd4, 2'b10,
             64'hFF00_0000_0000_000F);
    for (int m = 0; m < 4; m++) begin
      directed($sformatf("sh0_m%0d", m), 64'h8000_0000_0000_0001,
               6'd0, 2'(m), 64'h8000_0000_0000_0001);
    end

    // Idle: out_valid drops, dout holds.
    @(negedge clk);
    repeat (LAT) @(negedge clk);
    check("idle_valid", {63'd0, out_valid}, 64'd0);
    check("idle_hold", dout, 64'h8000_0000_0000_0001);

    // Full-rate random traffic with toggling in_valid.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      din      = {$urandom, $urandom};
      shamt    = 6'($urandom_range(0, 63));
      mode     = 2'($urandom_range(0, 3));
    end

    // Asynchronous reset mid-stream.
    @(negedge clk);
    in_valid = 1'b1;
    din      = 64'hFFFF_0000_FFFF_0000;
    mode     = 2'b11;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 64'd0);
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    directed("post_rst", 64'h0000_0000_0000_00FF, 6'd8, 2'b00,
             64'h0000_0000_0000_FF00);

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      din      = {$urandom, $urandom};
      shamt    = 6'($urandom_range(0, 63));
      mode     = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
